bram_arbiter: RTL and testbench
===============================

Name: bram_arbiter

Overview:
- Shares one single-port block RAM (existing `brams` module, registered output) between NREQ_ requesters.
- Each requester has a valid/ready request channel and a response strobe.
- Round-robin grant, one access per cycle, fixed 2-cycle read latency.
- Tracks the owner of each in-flight read so read data is returned to the requester that issued it.

Parameters:
- ADDR_, 8, address width; RAM depth = 2**ADDR_.
- DATA_, 8, data word width.
- NREQ_, 2, number of requesters (>= 2).

Ports:
- clk  input  1  single clock for all logic and the RAM.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NREQ_  per-requester request valid.
- req_ready  output  NREQ_  per-requester grant; one-hot or zero.
- req_we  input  NREQ_  per-requester write enable (1 = write, 0 = read).
- req_addr  input  NREQ_*ADDR_  packed addresses; requester i at bits [i*ADDR_ +: ADDR_].
- req_wdata  input  NREQ_*DATA_  packed write data, same packing as req_addr.
- rsp_valid  output  NREQ_  one-cycle read-data strobe, one-hot or zero.
- rsp_rdata  output  DATA_  read data, shared by all requesters; qualify with rsp_valid.

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rr pointer=0, in-flight pipeline cleared. rsp_rdata is don't-care while rsp_valid=0.
- Reset is asynchronous on all arbiter state. RAM contents are not reset.
- Arbitration is combinational in the request cycle.
  - Grant goes to the first i with req_valid[i]=1, searching i = ptr, ptr+1, ... modulo NREQ_.
  - req_ready[i]=1 only for the granted i. If no requester is valid, req_ready=0.
- A handshake is req_valid[i] && req_ready[i]. On a handshake:
  - ptr <= (i+1) mod NREQ_.
  - The granted addr, wdata and we drive the RAM.
  - No handshake: ptr holds and RAM we=0.
- Requesters must hold addr/we/wdata stable while valid && !ready. Dropping valid before ready is allowed; nothing is issued.
- Write: completes at the edge ending the handshake cycle. No response is generated.
- Read latency:
  - The handshake is in cycle T.
  - The RAM registers the address at the edge ending T; its output register updates at the edge ending T+1.
  - rsp_valid[i]=1 with rsp_rdata valid during cycle T+2, for exactly one cycle.
- In-flight tracking: a 2-stage pipeline of {valid, id} aligned with the RAM stages. Stage 0 is loaded only on a read handshake.
- Throughput: back-to-back handshakes every cycle. Up to 2 reads are in flight; no stall or backpressure on the response side.
- Read after write, same address, next cycle: returns the new data. Same-cycle read/write is impossible (single port).
- Idle cycles: the RAM address input holds its last value, we=0, and nothing enters the pipeline.
- Reset mid-operation: in-flight reads are discarded and no rsp_valid is produced for them. A write whose handshake edge coincides with reset assertion is undefined.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NREQ_-1,0,... Each requester waits at most NREQ_-1 cycles.

Optional Feature:
- Macro: BRAM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. The lowest index with valid wins every cycle; ptr is removed.
- Undefined (default): round-robin as above.
- Latency, handshake and response behaviour are identical in both modes.

Decomposition:
- Package bram_arb_pkg:
  - localparam RD_LAT_ = 2.
  - function/typedef for id width = $clog2(NREQ_), handling NREQ_=2 correctly.
  - typedef struct for in-flight stage {logic vld; id}. The struct is parameterised via id width, else a fixed max width.
- Sub-modules:
  - Reuse the existing brams module as the RAM instance, with ADDR_/DATA_ passed through.
  - Natural new sub-module: rr_arbiter (req vector in, one-hot grant out, advance input).

Test Plan (ADDR_=8, DATA_=8, NREQ_=2):
- Write 0xA5 to addr 0x10 via req 0, then read 0x10 via req 1 -> rsp_valid=2'b10, rsp_rdata=0xA5 exactly 2 cycles after the read handshake; rsp_valid[0] never set.
- Both requesters continuously valid reading addr 0x01 and 0x02 (preloaded 0x11/0x22) for 6 cycles -> grants alternate 0,1,0,1,...; rsp_valid alternates 01,10 with data 0x11,0x22 from cycle 2 onward.
- Req 0 reads addr 0x20 in cycle T and req 1 reads addr 0x21 in T+1 -> responses in T+2 (id 0) and T+3 (id 1), correct data, no gaps.
- Assert rst while two reads are in flight -> rsp_valid stays 0 through and after reset; req_ready=0 during reset; first grant after release goes to req 0.
- Write 0x3C to addr 0xFF, then read 0xFF in the immediately following cycle -> 0x3C returned (top-of-range address, no wrap error).
- With BRAM_ARB_FIXED_PRIO_EN defined and both requesters continuously valid for 4 cycles -> req 0 granted all 4 cycles, req_ready[1]=0 throughout.

Source files
------------

// File: rtl/bram_arb_pkg.sv
// ============================================================================
//  Module   : bram_arb_pkg
//  Brief    : Shared constants, id-width helper and in-flight stage type.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package bram_arb_pkg;

    localparam int RD_LAT_   = 2;
    localparam int ID_MAX_W_ = 8;

    // A single requester still needs one id bit so the vector stays legal.
    function automatic int id_width(input int nreq);
        if (nreq <= 2) begin
            return 1;
        end
        return $clog2(nreq);
    endfunction

    typedef struct packed {
        logic                 vld;
        logic [ID_MAX_W_-1:0] id;
    } inflight_t;

endpackage

`default_nettype wire

// File: rtl/brams.sv
// ============================================================================
//  Module   : brams
//  Brief    : Single-port block RAM, registered address and registered output.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module brams #(
    parameter int ADDR_ = 8,
    parameter int DATA_ = 8
) (
    input  logic             clk,
    input  logic             we,
    input  logic [ADDR_-1:0] addr,
    input  logic [DATA_-1:0] wdata,
    output logic [DATA_-1:0] rdata
);

    logic [DATA_-1:0] mem_q [2**ADDR_];
    logic [ADDR_-1:0] addr_q;
    logic [DATA_-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        addr_q  <= addr;
        rdata_q <= mem_q[addr_q];
    end

    assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
//  Module   : rr_arbiter
//  Brief    : One-hot grant, round-robin (or fixed priority with
//             BRAM_ARB_FIXED_PRIO_EN defined).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter
    import bram_arb_pkg::*;
#(
    parameter  int NREQ_ = 2,
    localparam int ID_W_ = id_width(NREQ_)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ_-1:0] req_i,
    input  logic             advance_i,
    output logic [NREQ_-1:0] grant_o,
    output logic [ID_W_-1:0] grant_idx_o
);

`ifdef BRAM_ARB_FIXED_PRIO_EN

    // Descending scan so the lowest valid index is the last one written.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        for (int i = NREQ_ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                grant_o     = '0;
                grant_o[i]  = 1'b1;
                grant_idx_o = ID_W_'(i);
            end
        end
    end

    logic w_unused;
    assign w_unused = ^{clk, rst, advance_i};

`else

    logic [ID_W_-1:0] ptr_q;
    logic [ID_W_-1:0] ptr_d;

    always_comb begin
        int   idx;
        logic found;
        idx         = 0;
        found       = 1'b0;
        grant_o     = '0;
        grant_idx_o = '0;
        for (int k = 0; k < NREQ_; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ_) begin
                idx = idx - NREQ_;
            end
            if (!found && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                grant_idx_o  = ID_W_'(idx);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i) begin
            ptr_d = ID_W_'((int'(grant_idx_o) + 1) % NREQ_);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

`endif

endmodule

`default_nettype wire

// File: rtl/bram_arbiter.sv
// ============================================================================
//  Module   : bram_arbiter
//  Brief    : Shares one single-port BRAM among NREQ_ requesters; routes read
//             data back to its issuer. Macro: BRAM_ARB_FIXED_PRIO_EN.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module bram_arbiter
    import bram_arb_pkg::*;
#(
    parameter int ADDR_ = 8,
    parameter int DATA_ = 8,
    parameter int NREQ_ = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ_-1:0]       req_valid,
    output logic [NREQ_-1:0]       req_ready,
    input  logic [NREQ_-1:0]       req_we,
    input  logic [NREQ_*ADDR_-1:0] req_addr,
    input  logic [NREQ_*DATA_-1:0] req_wdata,
    output logic [NREQ_-1:0]       rsp_valid,
    output logic [DATA_-1:0]       rsp_rdata
);

    localparam int ID_W_ = id_width(NREQ_);

    logic [NREQ_-1:0] w_req_gated;
    logic [NREQ_-1:0] w_grant;
    logic [ID_W_-1:0] w_grant_idx;
    logic             w_hs;
    logic             w_sel_we;
    logic [ADDR_-1:0] w_sel_addr;
    logic [DATA_-1:0] w_sel_wdata;
    logic             w_ram_we;
    logic [ADDR_-1:0] w_ram_addr;
    logic [DATA_-1:0] w_ram_rdata;
    logic [ADDR_-1:0] addr_hold_q;
    inflight_t        pipe_q [RD_LAT_];
    inflight_t        pipe_d [RD_LAT_];

    // No grant may be visible while reset is held.
    assign w_req_gated = rst ? '0 : req_valid;

    rr_arbiter #(
        .NREQ_(NREQ_)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .req_i       (w_req_gated),
        .advance_i   (w_hs),
        .grant_o     (w_grant),
        .grant_idx_o (w_grant_idx)
    );

    assign req_ready   = w_grant;
    assign w_hs        = |w_grant;
    assign w_sel_we    = req_we[w_grant_idx];
    assign w_sel_addr  = req_addr[int'(w_grant_idx)*ADDR_ +: ADDR_];
    assign w_sel_wdata = req_wdata[int'(w_grant_idx)*DATA_ +: DATA_];
    assign w_ram_we    = w_hs & w_sel_we;
    assign w_ram_addr  = w_hs ? w_sel_addr : addr_hold_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_hold_q <= '0;
        end else if (w_hs) begin
            addr_hold_q <= w_sel_addr;
        end
    end

    brams #(
        .ADDR_(ADDR_),
        .DATA_(DATA_)
    ) u_ram (
        .clk   (clk),
        .we    (w_ram_we),
        .addr  (w_ram_addr),
        .wdata (w_sel_wdata),
        .rdata (w_ram_rdata)
    );

    // Owner tags travel alongside the RAM's address and output registers.
    always_comb begin
        pipe_d[0].vld = w_hs & ~w_sel_we;
        pipe_d[0].id  = ID_MAX_W_'(w_grant_idx);
        for (int s = 1; s < RD_LAT_; s++) begin
            pipe_d[s] = pipe_q[s-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < RD_LAT_; s++) begin
                pipe_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < RD_LAT_; s++) begin
                pipe_q[s] <= pipe_d[s];
            end
        end
    end

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NREQ_; i++) begin
            rsp_valid[i] = pipe_q[RD_LAT_-1].vld &&
                           (pipe_q[RD_LAT_-1].id == ID_MAX_W_'(i));
        end
    end

    assign rsp_rdata = w_ram_rdata;

endmodule

`default_nettype wire

// File: tb/tb_bram_arbiter.sv
// ============================================================================
//  Module   : tb_bram_arbiter
//  Brief    : Randomised and directed checks of bram_arbiter against a
//             transaction-level model (grant rule, memory array, response queue).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bram_arbiter;

    localparam int NREQ = 2;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_we;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  rsp_valid;
    logic [7:0]  rsp_rdata;

    bram_arbiter #(.ADDR_(8), .DATA_(8), .NREQ_(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         due;
        int         id;
        logic [7:0] data;
        bit         known;
    } rsp_t;

    rsp_t       m_q[$];
    int         m_ptr;
    int         cyc;
    logic [7:0] m_mem [256];
    bit         m_known [256];

    int checks;
    int failures;

    logic [1:0] e_rdy, a_rdy, e_rv, a_rv;
    logic [7:0] e_rd, a_rd;
    bit         e_known;

    // One cycle: drive inputs, sample outputs, then advance the model.
    task automatic drive_cycle(input logic r, input logic [1:0] v, input logic [1:0] we,
                               input logic [7:0] a0, input logic [7:0] a1,
                               input logic [7:0] d0, input logic [7:0] d1);
        int g;
        int idx;
        logic [7:0] ad;
        rst       = r;
        req_valid = v;
        req_we    = we;
        req_addr  = {a1, a0};
        req_wdata = {d1, d0};
        #1;
        g = -1;
        if (!r) begin
            for (int k = 0; k < NREQ; k++) begin
`ifdef BRAM_ARB_FIXED_PRIO_EN
                idx = k;
`else
                idx = (m_ptr + k) % NREQ;
`endif
                if (g < 0 && v[idx]) g = idx;
            end
        end
        e_rdy = '0;
        if (g >= 0) e_rdy[g] = 1'b1;
        e_rv    = '0;
        e_rd    = '0;
        e_known = 1'b0;
        if (r) begin
            m_q.delete();
            m_ptr = 0;
        end else if (m_q.size() > 0 && m_q[0].due == cyc) begin
            e_rv[m_q[0].id] = 1'b1;
            e_rd    = m_q[0].data;
            e_known = m_q[0].known;
            void'(m_q.pop_front());
        end
        a_rdy = req_ready;
        a_rv  = rsp_valid;
        a_rd  = rsp_rdata;
        if (g >= 0) begin
            m_ptr = (g + 1) % NREQ;
            ad = (g == 0) ? a0 : a1;
            if (we[g]) begin
                m_mem[ad]   = (g == 0) ? d0 : d1;
                m_known[ad] = 1'b1;
            end else begin
                m_q.push_back('{cyc + 2, g, m_mem[ad], m_known[ad]});
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            drive_cycle(1'b1, 2'b11, 2'b00, 8'h01, 8'h02, 8'h00, 8'h00);
            checks++;
            if (a_rdy !== 2'b00) begin
                failures++;
                $display("FAIL reset_ready cyc=%0d got=%b exp=00", cyc, a_rdy);
            end
            checks++;
            if (a_rv !== 2'b00) begin
                failures++;
                $display("FAIL reset_rsp_valid cyc=%0d got=%b exp=00", cyc, a_rv);
            end
        end
    endtask

    task automatic test_write_read();
        bit seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            case (c)
                0:       drive_cycle(1'b0, 2'b01, 2'b01, 8'h10, 8'h00, 8'hA5, 8'h00);
                1:       drive_cycle(1'b0, 2'b10, 2'b00, 8'h00, 8'h10, 8'h00, 8'h00);
                default: drive_cycle(1'b0, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
            endcase
            if (a_rv === 2'b10 && a_rd === 8'hA5) seen = 1'b1;
            checks++;
            if (a_rdy !== e_rdy) begin
                failures++;
                $display("FAIL wr_rd_ready cyc=%0d got=%b exp=%b", cyc, a_rdy, e_rdy);
            end
            checks++;
            if (a_rv !== e_rv) begin
                failures++;
                $display("FAIL wr_rd_rsp_valid cyc=%0d got=%b exp=%b", cyc, a_rv, e_rv);
            end
            if (e_rv != 2'b00 && e_known) begin
                checks++;
                if (a_rd !== e_rd) begin
                    failures++;
                    $display("FAIL wr_rd_rdata cyc=%0d got=%h exp=%h", cyc, a_rd, e_rd);
                end
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL wr_rd_a5_returned got=none exp=rsp_valid=10 rdata=a5");
        end
    endtask

    task automatic test_alternate();
        for (int c = 0; c < 11; c++) begin
            case (c)
                0:       drive_cycle(1'b0, 2'b01, 2'b01, 8'h01, 8'h00, 8'h11, 8'h00);
                1:       drive_cycle(1'b0, 2'b10, 2'b10, 8'h00, 8'h02, 8'h00, 8'h22);
                2, 3, 4, 5, 6, 7:
                         drive_cycle(1'b0, 2'b11, 2'b00, 8'h01, 8'h02, 8'h00, 8'h00);
                default: drive_cycle(1'b0, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
            endcase
            checks++;
            if (a_rdy !== e_rdy) begin
                failures++;
                $display("FAIL alt_ready cyc=%0d got=%b exp=%b", cyc, a_rdy, e_rdy);
            end
            checks++;
            if (a_rv !== e_rv) begin
                failures++;
                $display("FAIL alt_rsp_valid cyc=%0d got=%b exp=%b", cyc, a_rv, e_rv);
            end
            if (e_rv != 2'b00 && e_known) begin
                checks++;
                if (a_rd !== e_rd) begin
                    failures++;
                    $display("FAIL alt_rdata cyc=%0d got=%h exp=%h", cyc, a_rd, e_rd);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 7; c++) begin
            case (c)
                0:       drive_cycle(1'b0, 2'b01, 2'b01, 8'h20, 8'h00, 8'h5A, 8'h00);
                1:       drive_cycle(1'b0, 2'b10, 2'b10, 8'h00, 8'h21, 8'h00, 8'hC3);
                2:       drive_cycle(1'b0, 2'b01, 2'b00, 8'h20, 8'h00, 8'h00, 8'h00);
                3:       drive_cycle(1'b0, 2'b10, 2'b00, 8'h00, 8'h21, 8'h00, 8'h00);
                default: drive_cycle(1'b0, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
            endcase
            checks++;
            if (a_rdy !== e_rdy) begin
                failures++;
                $display("FAIL b2b_ready cyc=%0d got=%b exp=%b", cyc, a_rdy, e_rdy);
            end
            checks++;
            if (a_rv !== e_rv) begin
                failures++;
                $display("FAIL b2b_rsp_valid cyc=%0d got=%b exp=%b", cyc, a_rv, e_rv);
            end
            if (e_rv != 2'b00 && e_known) begin
                checks++;
                if (a_rd !== e_rd) begin
                    failures++;
                    $display("FAIL b2b_rdata cyc=%0d got=%h exp=%h", cyc, a_rd, e_rd);
                end
            end
        end
    endtask

    task automatic test_reset_inflight();
        for (int c = 0; c < 9; c++) begin
            case (c)
                0, 1:    drive_cycle(1'b0, 2'b11, 2'b00, 8'h01, 8'h02, 8'h00, 8'h00);
                2, 3:    drive_cycle(1'b1, 2'b11, 2'b00, 8'h01, 8'h02, 8'h00, 8'h00);
                4, 5:    drive_cycle(1'b0, 2'b11, 2'b00, 8'h01, 8'h02, 8'h00, 8'h00);
                default: drive_cycle(1'b0, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
            endcase
            if (c == 4) begin
                checks++;
                if (a_rdy !== 2'b01) begin
                    failures++;
                    $display("FAIL rst_first_grant got=%b exp=01", a_rdy);
                end
            end
            checks++;
            if (a_rdy !== e_rdy) begin
                failures++;
                $display("FAIL rst_ready cyc=%0d got=%b exp=%b", cyc, a_rdy, e_rdy);
            end
            checks++;
            if (a_rv !== e_rv) begin
                failures++;
                $display("FAIL rst_rsp_valid cyc=%0d got=%b exp=%b", cyc, a_rv, e_rv);
            end
            if (e_rv != 2'b00 && e_known) begin
                checks++;
                if (a_rd !== e_rd) begin
                    failures++;
                    $display("FAIL rst_rdata cyc=%0d got=%h exp=%h", cyc, a_rd, e_rd);
                end
            end
        end
    endtask

    task automatic test_top_addr();
        bit seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            case (c)
                0:       drive_cycle(1'b0, 2'b01, 2'b01, 8'hFF, 8'h00, 8'h3C, 8'h00);
                1:       drive_cycle(1'b0, 2'b01, 2'b00, 8'hFF, 8'h00, 8'h00, 8'h00);
                default: drive_cycle(1'b0, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
            endcase
            if (a_rv === 2'b01 && a_rd === 8'h3C) seen = 1'b1;
            checks++;
            if (a_rv !== e_rv) begin
                failures++;
                $display("FAIL top_rsp_valid cyc=%0d got=%b exp=%b", cyc, a_rv, e_rv);
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL top_addr_3c_returned got=none exp=rsp_valid=01 rdata=3c");
        end
    endtask

`ifdef BRAM_ARB_FIXED_PRIO_EN
    task automatic test_fixed_prio();
        for (int c = 0; c < 4; c++) begin
            drive_cycle(1'b0, 2'b11, 2'b00, 8'h01, 8'h02, 8'h00, 8'h00);
            checks++;
            if (a_rdy !== 2'b01) begin
                failures++;
                $display("FAIL fixed_prio_ready cyc=%0d got=%b exp=01", cyc, a_rdy);
            end
        end
    endtask
`endif

    task automatic test_random();
        logic [1:0] pv, pwe;
        logic [7:0] pa [2];
        logic [7:0] pd [2];
        pv = '0;
        pwe = '0;
        for (int i = 0; i < 2; i++) begin
            pa[i] = '0;
            pd[i] = '0;
        end
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pv[i] && ($urandom % 3) != 0) begin
                    pv[i]  = 1'b1;
                    pwe[i] = ($urandom % 3) == 0;
                    pa[i]  = 8'($urandom % 16);
                    pd[i]  = 8'($urandom);
                end else if (pv[i] && ($urandom % 8) == 0) begin
                    pv[i] = 1'b0;
                end
            end
            drive_cycle(1'b0, pv, pwe, pa[0], pa[1], pd[0], pd[1]);
            checks++;
            if (a_rdy !== e_rdy) begin
                failures++;
                $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, a_rdy, e_rdy);
            end
            checks++;
            if (a_rv !== e_rv) begin
                failures++;
                $display("FAIL rand_rsp_valid cyc=%0d got=%b exp=%b", cyc, a_rv, e_rv);
            end
            if (e_rv != 2'b00 && e_known) begin
                checks++;
                if (a_rd !== e_rd) begin
                    failures++;
                    $display("FAIL rand_rdata cyc=%0d got=%h exp=%h", cyc, a_rd, e_rd);
                end
            end
            pv = pv & ~e_rdy;
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        cyc       = 0;
        m_ptr     = 0;
        rst       = 1'b1;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < 256; i++) begin
            m_mem[i]   = '0;
            m_known[i] = 1'b0;
        end
        @(negedge clk);
        test_reset();
        test_write_read();
        test_alternate();
        test_back_to_back();
        test_reset_inflight();
        test_top_addr();
`ifdef BRAM_ARB_FIXED_PRIO_EN
        test_fixed_prio();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
